// File: rtl/copro_exec_unit_pkg.sv
// Shared types for the coprocessor execution stage: decoded opcodes, FSM states and FIFO entries.
package copro_exec_unit_pkg;

  localparam int unsigned CoproXlen       = 32;
  localparam int unsigned CoproIdWidth    = 3;
  localparam int unsigned MultiLatDefault = 4;

  typedef enum logic [3:0] {
    ILLEGAL      = 4'd0,
    NOP          = 4'd1,
    ADD          = 4'd2,
    DOUBLE_RS1   = 4'd3,
    DOUBLE_RS2   = 4'd4,
    ADD_MULTI    = 4'd5,
    ADD_RS3_R    = 4'd6,
    MADD_RS3_R4  = 4'd7,
    MSUB_RS3_R4  = 4'd8,
    NMADD_RS3_R4 = 4'd9,
    NMSUB_RS3_R4 = 4'd10,
    ROR64H       = 4'd11,
    ROR64L       = 4'd12
  } opcode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    MULTI = 1'b1
  } exec_state_t;

  typedef struct packed {
    logic [CoproXlen-1:0]    data;
    logic [4:0]              rd;
    logic [CoproIdWidth-1:0] id;
    logic                    we;
  } copro_result_t;

  function automatic logic has_writeback(opcode_t op);
    return !(op == NOP || op == ILLEGAL);
  endfunction

endpackage

// File: rtl/copro_exec_unit_if.sv
// Issue and result channels between the decoder/core and the execution stage.
interface copro_exec_unit_if
  import copro_exec_unit_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NrRs    = 3,
  parameter int unsigned IdWidth = 3
) ();

  logic                       issue_valid_i;
  logic                       issue_ready_o;
  opcode_t                    opcode_i;
  logic [NrRs-1:0][XLEN-1:0]  rs_i;
  logic [5:0]                 shamt_i;
  logic [4:0]                 rd_i;
  logic [IdWidth-1:0]         id_i;
  logic                       we_i;

  logic                       result_valid_o;
  logic                       result_ready_i;
  logic [XLEN-1:0]            result_data_o;
  logic [4:0]                 result_rd_o;
  logic [IdWidth-1:0]         result_id_o;
  logic                       result_we_o;

  modport master (
    output issue_valid_i, opcode_i, rs_i, shamt_i, rd_i, id_i, we_i, result_ready_i,
    input  issue_ready_o, result_valid_o, result_data_o, result_rd_o, result_id_o, result_we_o
  );

  modport slave (
    input  issue_valid_i, opcode_i, rs_i, shamt_i, rd_i, id_i, we_i, result_ready_i,
    output issue_ready_o, result_valid_o, result_data_o, result_rd_o, result_id_o, result_we_o
  );

endinterface

// File: rtl/copro_exec_unit_result_fifo.sv
// In-order circular result queue; head is zeroed while empty so idle outputs read 0.
module copro_result_fifo
  import copro_exec_unit_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  copro_result_t push_dat_i,
  input  logic          pop_i,
  output copro_result_t head_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam int unsigned AW = $clog2(Depth);

  copro_result_t mem_q [Depth];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop_i && !push_i) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage is not reset: occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= push_dat_i;
  end

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(Depth));
  assign head_o  = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/copro_exec_unit.sv
// Coprocessor execute stage: combinational ALU, countdown FSM for ADD_MULTI, in-order result FIFO.
module copro_exec_unit
  import copro_exec_unit_pkg::*;
#(
  parameter int unsigned XLEN      = CoproXlen,
  parameter int unsigned NrRs      = 3,
  parameter int unsigned IdWidth   = CoproIdWidth,
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned MultiLat  = MultiLatDefault
) (
  input  logic               clk_i,
  input  logic               rst_i,
  copro_exec_unit_if.slave   io,
  output logic               busy_o
);

  localparam int unsigned CntW = $clog2(MultiLat);

  logic [NrRs-1:0][XLEN-1:0] rs;
  logic [IdWidth-1:0]        id_w;
  logic [2*XLEN-1:0]         ror_v, ror_w;
  logic [XLEN-1:0]           alu_data;
  copro_result_t             alu_res, multi_q, push_dat, head;
  exec_state_t               state_q;
  logic [CntW-1:0]           cnt_q;
  logic                      issue_fire, is_multi, multi_done, push, pop;
  logic                      fifo_full, fifo_empty;

  assign rs   = io.rs_i;
  assign id_w = io.id_i;

  always_comb begin
    ror_v = {rs[0], rs[1]};
    // A 64-bit left shift by 64 yields zero, so shamt=0 stays the identity.
    ror_w = (ror_v >> io.shamt_i) | (ror_v << (7'(2*XLEN) - {1'b0, io.shamt_i}));
    alu_data = '0;
    case (io.opcode_i)
      ADD, ADD_MULTI:           alu_data = rs[0] + rs[1];
      DOUBLE_RS1:               alu_data = rs[0] + rs[0];
      DOUBLE_RS2:               alu_data = rs[1] + rs[1];
      ADD_RS3_R, MADD_RS3_R4:   alu_data = rs[0] + rs[1] + rs[2];
      MSUB_RS3_R4:              alu_data = rs[0] - rs[1] - rs[2];
      NMADD_RS3_R4:             alu_data = ~(rs[0] + rs[1] + rs[2]);
      NMSUB_RS3_R4:             alu_data = ~(rs[0] - rs[1] - rs[2]);
      ROR64H:                   alu_data = ror_w[2*XLEN-1:XLEN];
      ROR64L:                   alu_data = ror_w[XLEN-1:0];
      default:                  alu_data = '0;
    endcase
    alu_res.data = alu_data;
    alu_res.rd   = io.rd_i;
    alu_res.id   = id_w;
    alu_res.we   = io.we_i && has_writeback(io.opcode_i);
  end

  assign io.issue_ready_o = (state_q == IDLE) && !fifo_full;
  assign issue_fire       = io.issue_valid_i && io.issue_ready_o;
  assign is_multi         = (io.opcode_i == ADD_MULTI);
  assign multi_done       = (state_q == MULTI) && (cnt_q == '0);

  // Issue is blocked during MULTI, so the two push sources never collide.
  assign push     = (issue_fire && !is_multi) || multi_done;
  assign push_dat = multi_done ? multi_q : alu_res;
  assign pop      = io.result_valid_o && io.result_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      multi_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue_fire && is_multi) begin
            state_q <= MULTI;
            cnt_q   <= CntW'(MultiLat - 2);
            multi_q <= alu_res;
          end
        end
        MULTI: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  copro_result_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_o     (head),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  assign io.result_valid_o = !fifo_empty;
  assign io.result_data_o  = head.data;
  assign io.result_rd_o    = head.rd;
  assign io.result_id_o    = head.id;
  assign io.result_we_o    = head.we;
  assign busy_o            = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_copro_exec_unit.sv
// Bench for copro_exec_unit: directed scenarios plus a randomized run against an occupancy/queue model.
module tb_copro_exec_unit;
  import copro_exec_unit_pkg::*;

  localparam int ML = 4;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  copro_exec_unit_if #(.XLEN(32), .NrRs(3), .IdWidth(3)) bus ();

  copro_exec_unit #(
    .XLEN(32), .NrRs(3), .IdWidth(3), .FifoDepth(FD), .MultiLat(ML)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .io     (bus),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  function automatic copro_result_t model(opcode_t op, logic [31:0] a, logic [31:0] b, logic [31:0] c,
                                          logic [5:0] sh, logic [4:0] rd, logic [2:0] id, logic we);
    copro_result_t r;
    logic [63:0] v, rot;
    v = {a, b};
    rot = (v >> sh) | (v << (64 - sh));
    r.rd = rd; r.id = id; r.we = we; r.data = '0;
    case (op)
      ADD, ADD_MULTI:         r.data = a + b;
      DOUBLE_RS1:             r.data = a * 2;
      DOUBLE_RS2:             r.data = b * 2;
      ADD_RS3_R, MADD_RS3_R4: r.data = a + b + c;
      MSUB_RS3_R4:            r.data = a - b - c;
      NMADD_RS3_R4:           r.data = ~(a + b + c);
      NMSUB_RS3_R4:           r.data = ~(a - b - c);
      ROR64H:                 r.data = rot[63:32];
      ROR64L:                 r.data = rot[31:0];
      default:                begin r.data = '0; r.we = 1'b0; end
    endcase
    return r;
  endfunction

  task automatic set_issue(opcode_t op, logic [31:0] a, logic [31:0] b, logic [31:0] c,
                           logic [5:0] sh, logic [4:0] rd, logic [2:0] id, logic we);
    bus.issue_valid_i = 1'b1;
    bus.opcode_i = op;
    bus.rs_i[0] = a; bus.rs_i[1] = b; bus.rs_i[2] = c;
    bus.shamt_i = sh; bus.rd_i = rd; bus.id_i = id; bus.we_i = we;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.result_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", bus.result_valid_o); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (bus.issue_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", bus.issue_ready_o); end
    total++; if ({bus.result_data_o, bus.result_rd_o, bus.result_id_o, bus.result_we_o} !== '0) begin
      bad++; $display("FAIL reset_outputs got %h/%0d/%0d/%b want 0", bus.result_data_o, bus.result_rd_o, bus.result_id_o, bus.result_we_o);
    end
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.issue_ready_o !== 1'b1) begin bad++; $display("FAIL post_reset_ready got %b want 1", bus.issue_ready_o); end
  endtask

  task automatic test_add();
    bus.result_ready_i = 1'b1;
    set_issue(ADD, 32'hFFFF_FFFF, 32'd2, 32'd0, 6'd0, 5'd5, 3'd1, 1'b1);
    @(negedge clk);
    bus.issue_valid_i = 1'b0;
    total++; if (bus.result_valid_o !== 1'b1) begin bad++; $display("FAIL add_valid got %b want 1", bus.result_valid_o); end
    total++; if ({bus.result_data_o, bus.result_rd_o, bus.result_id_o, bus.result_we_o} !== {32'h1, 5'd5, 3'd1, 1'b1}) begin
      bad++; $display("FAIL add_result got %h/%0d/%0d/%b want 1/5/1/1", bus.result_data_o, bus.result_rd_o, bus.result_id_o, bus.result_we_o);
    end
    @(negedge clk);
    total++; if (bus.result_valid_o !== 1'b0) begin bad++; $display("FAIL add_drained got %b want 0", bus.result_valid_o); end
  endtask

  task automatic test_ror();
    opcode_t     ops [3] = '{ROR64L, ROR64H, ROR64H};
    logic [5:0]  shs [3] = '{6'd8, 6'd8, 6'd32};
    logic [31:0] exp [3] = '{32'h789A_BCDE, 32'hF012_3456, 32'h9ABC_DEF0};
    bus.result_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_issue(ops[i], 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, shs[i], 5'd7, 3'(i), 1'b1);
      @(negedge clk);
      total++; if (bus.result_valid_o !== 1'b1 || bus.result_data_o !== exp[i]) begin
        bad++; $display("FAIL ror_%0d got v=%b %h want v=1 %h", i, bus.result_valid_o, bus.result_data_o, exp[i]);
      end
    end
    bus.issue_valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_we();
    opcode_t     ops [4] = '{NOP, ILLEGAL, NMSUB_RS3_R4, NMSUB_RS3_R4};
    logic        wei [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] exd [4] = '{32'h0, 32'h0, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
    logic        exw [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    bus.result_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_issue(ops[i], 32'd5, 32'd2, 32'd1, 6'd3, 5'd9, 3'd2, wei[i]);
      @(negedge clk);
      total++; if (bus.result_valid_o !== 1'b1 || bus.result_data_o !== exd[i] || bus.result_we_o !== exw[i]) begin
        bad++; $display("FAIL we_%0d got v=%b d=%h we=%b want v=1 d=%h we=%b", i, bus.result_valid_o, bus.result_data_o, bus.result_we_o, exd[i], exw[i]);
      end
    end
    bus.issue_valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multi();
    bus.result_ready_i = 1'b1;
    set_issue(ADD_MULTI, 32'd3, 32'd4, 32'd0, 6'd0, 5'd3, 3'd4, 1'b1);
    @(negedge clk);
    set_issue(ADD, 32'd10, 32'd20, 32'd0, 6'd0, 5'd4, 3'd5, 1'b1);
    for (int k = 1; k < ML; k++) begin
      total++; if (bus.issue_ready_o !== 1'b0 || bus.result_valid_o !== 1'b0) begin
        bad++; $display("FAIL multi_wait_c%0d got rdy=%b v=%b want rdy=0 v=0", k, bus.issue_ready_o, bus.result_valid_o);
      end
      @(negedge clk);
    end
    total++; if (bus.issue_ready_o !== 1'b1 || bus.result_valid_o !== 1'b1 || bus.result_data_o !== 32'd7 || bus.result_id_o !== 3'd4) begin
      bad++; $display("FAIL multi_result got rdy=%b v=%b d=%h id=%0d want 1 1 7 4", bus.issue_ready_o, bus.result_valid_o, bus.result_data_o, bus.result_id_o);
    end
    @(negedge clk);
    bus.issue_valid_i = 1'b0;
    total++; if (bus.result_valid_o !== 1'b1 || bus.result_data_o !== 32'd30 || bus.result_id_o !== 3'd5) begin
      bad++; $display("FAIL multi_follow got v=%b d=%h id=%0d want 1 1e 5", bus.result_valid_o, bus.result_data_o, bus.result_id_o);
    end
    @(negedge clk);
    total++; if (bus.result_valid_o !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL multi_idle got v=%b busy=%b want 0 0", bus.result_valid_o, busy); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [5];
    bus.result_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp[i] = 32'h11 * (i + 1) + i;
      set_issue(ADD, 32'h11 * (i + 1), 32'(i), 32'd0, 6'd0, 5'(i), 3'(i), 1'b1);
      total++; if (bus.issue_ready_o !== 1'b1) begin bad++; $display("FAIL bp_ready_%0d got %b want 1", i, bus.issue_ready_o); end
      @(negedge clk);
    end
    bus.issue_valid_i = 1'b0;
    total++; if (bus.issue_ready_o !== 1'b0 || bus.result_data_o !== exp[0]) begin
      bad++; $display("FAIL bp_full got rdy=%b d=%h want rdy=0 d=%h", bus.issue_ready_o, bus.result_data_o, exp[0]);
    end
    bus.result_ready_i = 1'b1;
    @(negedge clk);
    bus.result_ready_i = 1'b0;
    total++; if (bus.issue_ready_o !== 1'b1 || bus.result_data_o !== exp[1]) begin
      bad++; $display("FAIL bp_one_pop got rdy=%b d=%h want rdy=1 d=%h", bus.issue_ready_o, bus.result_data_o, exp[1]);
    end
    exp[4] = 32'hABCD_0000 + 32'h5;
    set_issue(ADD, 32'hABCD_0000, 32'h5, 32'd0, 6'd0, 5'd4, 3'd4, 1'b1);
    @(negedge clk);
    bus.issue_valid_i = 1'b0;
    total++; if (bus.issue_ready_o !== 1'b0) begin bad++; $display("FAIL bp_refull got %b want 0", bus.issue_ready_o); end
    bus.result_ready_i = 1'b1;
    for (int k = 1; k < 5; k++) begin
      total++; if (bus.result_valid_o !== 1'b1 || bus.result_data_o !== exp[k]) begin
        bad++; $display("FAIL bp_drain_%0d got v=%b d=%h want v=1 d=%h", k, bus.result_valid_o, bus.result_data_o, exp[k]);
      end
      @(negedge clk);
    end
    total++; if (bus.result_valid_o !== 1'b0) begin bad++; $display("FAIL bp_empty got %b want 0", bus.result_valid_o); end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    bus.result_ready_i = 1'b0;
    set_issue(ADD, 32'd1, 32'd1, 32'd0, 6'd0, 5'd1, 3'd1, 1'b1);
    @(negedge clk);
    set_issue(ADD, 32'd2, 32'd2, 32'd0, 6'd0, 5'd2, 3'd2, 1'b1);
    @(negedge clk);
    set_issue(ADD_MULTI, 32'd3, 32'd3, 32'd0, 6'd0, 5'd3, 3'd3, 1'b1);
    @(negedge clk);
    bus.issue_valid_i = 1'b0;
    total++; if (busy !== 1'b1 || bus.issue_ready_o !== 1'b0) begin bad++; $display("FAIL rmid_in_multi got busy=%b rdy=%b want 1 0", busy, bus.issue_ready_o); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (bus.result_valid_o !== 1'b0 || busy !== 1'b0 || bus.issue_ready_o !== 1'b1) begin
      bad++; $display("FAIL rmid_after got v=%b busy=%b rdy=%b want 0 0 1", bus.result_valid_o, busy, bus.issue_ready_o);
    end
    bus.result_ready_i = 1'b1;
    for (int k = 0; k < ML + 4; k++) begin
      @(negedge clk);
      if (bus.result_valid_o !== 1'b0) stale++;
    end
    total++; if (stale !== 0) begin bad++; $display("FAIL rmid_stale got %0d valid cycles want 0", stale); end
  endtask

  task automatic test_random();
    int occ = 0;
    int mleft = 0;
    copro_result_t q[$];
    copro_result_t obs, expr;
    logic exp_rdy, exp_busy, rr, vi, fire, popping, pushing;
    opcode_t op;
    logic [31:0] a, b, c;
    logic [5:0] sh;
    logic [4:0] rd;
    logic [2:0] id;
    logic we;
    for (int cyc = 0; cyc < 420; cyc++) begin
      exp_rdy  = (mleft == 0) && (occ < FD);
      exp_busy = (mleft > 0) || (occ > 0);
      total++; if (bus.issue_ready_o !== exp_rdy) begin bad++; $display("FAIL rnd_ready c%0d got %b want %b", cyc, bus.issue_ready_o, exp_rdy); end
      total++; if (bus.result_valid_o !== (occ > 0)) begin bad++; $display("FAIL rnd_valid c%0d got %b want %b", cyc, bus.result_valid_o, occ > 0); end
      total++; if (busy !== exp_busy) begin bad++; $display("FAIL rnd_busy c%0d got %b want %b", cyc, busy, exp_busy); end
      rr = (cyc >= 400) ? 1'b1 : ($urandom_range(0, 99) < 60);
      vi = (cyc >= 400) ? 1'b0 : ($urandom_range(0, 99) < 70);
      op = opcode_t'($urandom_range(0, 12));
      a = $urandom; b = $urandom; c = $urandom;
      sh = 6'($urandom_range(0, 63)); rd = 5'($urandom); id = 3'($urandom); we = 1'($urandom);
      set_issue(op, a, b, c, sh, rd, id, we);
      bus.issue_valid_i = vi;
      bus.result_ready_i = rr;
      fire    = vi && exp_rdy;
      popping = rr && (occ > 0);
      if (popping) begin
        expr = q.pop_front();
        obs.data = bus.result_data_o; obs.rd = bus.result_rd_o; obs.id = bus.result_id_o; obs.we = bus.result_we_o;
        total++; if (obs !== expr) begin
          bad++; $display("FAIL rnd_data c%0d got %h/%0d/%0d/%b want %h/%0d/%0d/%b", cyc, obs.data, obs.rd, obs.id, obs.we, expr.data, expr.rd, expr.id, expr.we);
        end
      end
      pushing = (fire && op != ADD_MULTI) || (mleft == 1);
      if (fire) q.push_back(model(op, a, b, c, sh, rd, id, we));
      occ = occ + int'(pushing) - int'(popping);
      if (mleft > 0) mleft--;
      if (fire && op == ADD_MULTI) mleft = ML - 1;
      @(negedge clk);
    end
    bus.issue_valid_i = 1'b0;
    total++; if (q.size() != 0 || bus.result_valid_o !== 1'b0) begin
      bad++; $display("FAIL rnd_final got q=%0d v=%b want 0 0", q.size(), bus.result_valid_o);
    end
  endtask

  initial begin
    bus.issue_valid_i = 1'b0;
    bus.result_ready_i = 1'b0;
    bus.opcode_i = NOP;
    bus.rs_i = '0;
    bus.shamt_i = '0;
    bus.rd_i = '0;
    bus.id_i = '0;
    bus.we_i = 1'b0;
    test_reset();
    test_add();
    test_ror();
    test_we();
    test_multi();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/copro_exec_unit.md
# copro_exec_unit

Execution stage of the CV-X-IF example coprocessor. It sits directly downstream of the instruction decoder, which matches `instr`/`mask` entries and emits an `opcode_t`. The unit accepts one decoded instruction per cycle together with its source operands, computes the result (single-cycle ops, plus one multi-cycle op under a countdown FSM), and queues results in order in a small FIFO for the CV-X-IF result interface.

## Interface
Parameters:
- `XLEN`, 32, operand/result width
- `NrRs`, 3, number of source operands
- `IdWidth`, 3, CV-X-IF instruction id width
- `FifoDepth`, 4, result FIFO entries (power of two, ≥2)
- `MultiLat`, 4, ADD_MULTI latency in cycles (≥2)

Ports:
- `clk_i`  in  1  clock, all state on rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `issue_valid_i`  in  1  decoded instruction valid
- `issue_ready_o`  out  1  unit can accept
- `opcode_i`  in  `opcode_t`  decoded opcode
- `rs_i`  in  `NrRs`×`XLEN`  operands, `rs_i[0]` = rs1
- `shamt_i`  in  6  rotate amount for ROR64H/ROR64L
- `rd_i`  in  5  destination register
- `id_i`  in  `IdWidth`  instruction id
- `we_i`  in  1  writeback requested by the decoder
- `result_valid_o`  out  1  FIFO head valid
- `result_ready_i`  in  1  core takes the result
- `result_data_o`  out  `XLEN`  result value
- `result_rd_o`  out  5  destination register
- `result_id_o`  out  `IdWidth`  instruction id
- `result_we_o`  out  1  register-file write enable
- `busy_o`  out  1  FSM not IDLE, or FIFO non-empty

## Operation
- Handshake: issue fires when `issue_valid_i && issue_ready_o`. `issue_ready_o = (state==IDLE) && !fifo_full`. There is no full-and-pop bypass.
- Results, all arithmetic modulo 2^XLEN:
  - ADD: rs1+rs2
  - DOUBLE_RS1: rs1+rs1
  - DOUBLE_RS2: rs2+rs2
  - ADD_RS3_R and MADD_RS3_R4: rs1+rs2+rs3
  - MSUB_RS3_R4: rs1−rs2−rs3
  - NMADD_RS3_R4: ~(rs1+rs2+rs3)
  - NMSUB_RS3_R4: ~(rs1−rs2−rs3)
  - ADD_MULTI: rs1+rs2, multi-cycle
  - ROR64H/ROR64L: form v = {rs1, rs2} (rs1 high) and compute r = v rotated right by `shamt_i`. ROR64H returns r[63:32]; ROR64L returns r[31:0]. `shamt_i`=0 is identity; 32 swaps the words.
  - NOP and ILLEGAL: data 0 and `result_we_o`=0.
  - All other opcodes: `result_we_o = we_i`.
- Single-cycle ops are pushed into the FIFO on the issue edge.
- FSM states:
  - IDLE → MULTI on ADD_MULTI issue: operands, rd, id and we are latched, and `cnt` is loaded with `MultiLat`−2.
  - MULTI: `cnt` decrements each cycle. When `cnt`==0, the latched result is pushed and the FSM returns to IDLE. The FIFO cannot fill during MULTI, so the push never stalls.
- FIFO: circular buffer, read/write pointers of log2(`FifoDepth`) bits that wrap, plus an occupancy count of log2+1 bits. Simultaneous push and pop leaves the count unchanged. A pop while empty is impossible because `result_valid_o` is 0.
- Result ordering equals issue order.

## Timing
- Single-cycle op issued at edge t → `result_valid_o`=1 in the cycle after t (latency 1).
- ADD_MULTI issued at edge t → push at edge t+`MultiLat`−1 → valid in cycle t+`MultiLat`. `issue_ready_o`=0 from t+1 until after the push edge.
- Result outputs are stable while `result_valid_o && !result_ready_i`.
- Reset values:
  - FSM=IDLE, `cnt`=0, pointers and count=0
  - `result_valid_o`=0, `busy_o`=0, `issue_ready_o`=1
  - `result_data_o`, `result_rd_o`, `result_id_o`, `result_we_o` = 0
- Reset mid-MULTI or with a non-empty FIFO discards everything. The first post-reset cycle has `issue_ready_o`=1.

## Structure
- `opcode_t` comes from the existing coprocessor instruction package. Add `MultiLat` default and a `copro_result_t` struct {data, rd, id, we} there.
- Natural sub-module: `copro_result_fifo`, a parameterised in-order FIFO of `copro_result_t`.
- Combinational ALU lives in this module.

## Test plan
- ADD rs1=0xFFFF_FFFF, rs2=2, rd=5, id=1, ready=1 → next cycle valid, data 0x1, rd 5, id 1, we 1.
- ROR64L rs1=0x1234_5678, rs2=0x9ABC_DEF0, shamt=8 → 0x789A_BCDE. ROR64H same inputs → 0xF012_3456. shamt=32 with ROR64H → 0x9ABC_DEF0.
- ADD_MULTI 3+4 at edge 0, `MultiLat`=4 → `issue_ready_o` low cycles 1–3, valid data 7 in cycle 4. A back-to-back ADD is accepted at edge 4 and its result follows in order.
- `result_ready_i`=0, four ADDs issued → `issue_ready_o` drops after the 4th. Raising ready for one cycle pops one entry, and ready returns the next cycle. Drained data matches issue order across pointer wrap.
- NOP, ILLEGAL, and NMSUB (5,2,1) → we=0 / we=0 / data 0xFFFF_FFFD, we=`we_i`.
- `rst_i` asserted during MULTI with 2 FIFO entries → next cycle valid=0, busy=0, ready=1, and no stale result appears afterwards.
